// File: rtl/lz77_pkg.sv
// Shared LZ77 token format and decoder state encoding, used by both the
// compressor and the decompressor.
package lz77_pkg;

  localparam int LZ77_WINDOW_SIZE  = 1023;
  localparam int LZ77_OFFSET_BITS  = 12;
  localparam int LZ77_LENGTH_BITS  = 6;
  localparam int LZ77_MIN_MATCH    = 3;
  localparam int LZ77_LITERAL_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    FLAG,
    LITERAL,
    MATCH_HDR,
    COPY,
    DONE,
    ERROR
  } lz77_state_e;

endpackage

// File: rtl/lz77_decompressor_if.sv
// Serial token input and byte output handshakes of the LZ77 decompressor.
interface lz77_decompressor_if;
  logic       inBit;
  logic       inValid;
  logic       inReady;
  logic       lastToken;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;

  modport master (
    output inBit, inValid, lastToken, outReady,
    input  inReady, outData, outValid
  );

  modport slave (
    input  inBit, inValid, lastToken, outReady,
    output inReady, outData, outValid
  );
endinterface

// File: rtl/lz77_window_ram.sv
// History window: one write port and one registered read port with enable,
// returning the incoming write data when both ports hit the same address.
module lz77_window_ram #(
  parameter int DEPTH  = 1023,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; its contents are
  // meaningless until written, and the decoder never reads an unwritten slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/lz77_decompressor.sv
// Bit-serial LZ77 token decoder: literals and (offset,length) matches against
// a circular history window whose offset 0 is the oldest stored byte.
module lz77_decompressor
  import lz77_pkg::*;
#(
  parameter int WINDOW_SIZE = LZ77_WINDOW_SIZE,
  parameter int OFFSET_BITS = LZ77_OFFSET_BITS,
  parameter int LENGTH_BITS = LZ77_LENGTH_BITS,
  parameter int MIN_MATCH   = LZ77_MIN_MATCH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [31:0]        bytesWritten,
  lz77_decompressor_if.slave stream
);

  localparam int HDR_W  = OFFSET_BITS + LENGTH_BITS;
  localparam int BCNT_W = $clog2(HDR_W + 1);
  localparam int PTR_W  = $clog2(WINDOW_SIZE);
  localparam int CNT_W  = $clog2(WINDOW_SIZE + 1);

  lz77_state_e            state, state_next;
  logic [BCNT_W-1:0]      bit_cnt;
  logic [HDR_W-2:0]       shift_q;
  logic [HDR_W-1:0]       hdr_word;
  logic [OFFSET_BITS-1:0] hdr_offset;
  logic [LENGTH_BITS-1:0] hdr_length;
  logic                   last_tok;
  logic                   out_valid;
  logic [7:0]             out_data;
  logic [31:0]            bytes_written;
  logic [CNT_W-1:0]       chars;
  logic [PTR_W-1:0]       window_ptr, wr_ptr, src_ptr;
  logic [LENGTH_BITS-1:0] remaining;
  logic                   rd_pend;
  logic                   in_ready, bit_xfer, out_fire, slot_free;
  logic                   lit_end, hdr_end, hdr_bad, window_full;
  logic                   copy_issue, copy_load;
  logic                   ram_we, ram_re;
  logic [7:0]             ram_wdata, ram_rdata;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [31:0] step);
    logic [31:0] sum;
    sum = 32'(base) + step;
    if (sum >= 32'(WINDOW_SIZE)) sum = sum - 32'(WINDOW_SIZE);
    return PTR_W'(sum);
  endfunction

  assign in_ready    = (state inside {FLAG, LITERAL, MATCH_HDR}) && !out_valid;
  assign bit_xfer    = in_ready && stream.inValid;
  assign out_fire    = out_valid && stream.outReady;
  assign slot_free   = !out_valid || stream.outReady;
  assign hdr_word    = {shift_q, stream.inBit};
  assign hdr_offset  = hdr_word[HDR_W-1:LENGTH_BITS];
  assign hdr_length  = hdr_word[LENGTH_BITS-1:0];
  assign lit_end     = (bit_cnt == BCNT_W'(LZ77_LITERAL_BITS - 1));
  assign hdr_end     = (bit_cnt == BCNT_W'(HDR_W - 1));
  assign window_full = (32'(chars) == 32'(WINDOW_SIZE));
  assign hdr_bad     = (32'(hdr_offset) >= 32'(chars)) || (32'(hdr_length) < 32'(MIN_MATCH));

  // A read is issued only if its data can be taken next cycle or held in the
  // RAM output register; a pending byte is consumed once the output slot frees.
  assign copy_load  = (state == COPY) && rd_pend && slot_free;
  assign copy_issue = (state == COPY) && (remaining != '0) && (!rd_pend || slot_free);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_wdata  = ram_rdata;
    case (state)
      IDLE:      if (start) state_next = FLAG;
      FLAG:      if (bit_xfer) state_next = stream.inBit ? LITERAL : MATCH_HDR;
      LITERAL: begin
        if (out_fire) begin
          state_next = last_tok ? DONE : FLAG;
        end else if (bit_xfer && lit_end) begin
          ram_we    = 1'b1;
          ram_wdata = hdr_word[7:0];
        end
      end
      MATCH_HDR: if (bit_xfer && hdr_end) state_next = hdr_bad ? ERROR : COPY;
      COPY: begin
        ram_re = copy_issue;
        ram_we = copy_load;
        if (remaining == '0 && !rd_pend && out_fire) state_next = last_tok ? DONE : FLAG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      shift_q       <= '0;
      last_tok      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      bytes_written <= '0;
      chars         <= '0;
      window_ptr    <= '0;
      wr_ptr        <= '0;
      src_ptr       <= '0;
      remaining     <= '0;
      rd_pend       <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid     <= 1'b0;
        bytes_written <= bytes_written + 32'd1;
      end
      if (bit_xfer) begin
        shift_q <= hdr_word[HDR_W-2:0];
        bit_cnt <= bit_cnt + BCNT_W'(1);
        if (state == FLAG) begin
          bit_cnt  <= '0;
          last_tok <= stream.lastToken;
        end else if (state == LITERAL && lit_end) begin
          bit_cnt   <= '0;
          out_data  <= hdr_word[7:0];
          out_valid <= 1'b1;
        end else if (state == MATCH_HDR && hdr_end) begin
          bit_cnt   <= '0;
          src_ptr   <= wrap_add(window_ptr, 32'(hdr_offset));
          remaining <= hdr_length;
        end
      end
      if (copy_issue) begin
        src_ptr   <= wrap_add(src_ptr, 32'd1);
        remaining <= remaining - LENGTH_BITS'(1);
      end
      if (copy_issue)     rd_pend <= 1'b1;
      else if (copy_load) rd_pend <= 1'b0;
      if (copy_load) begin
        out_data  <= ram_rdata;
        out_valid <= 1'b1;
      end
      // Once the window is full each append overwrites the oldest byte.
      if (ram_we) begin
        wr_ptr <= wrap_add(wr_ptr, 32'd1);
        if (window_full) window_ptr <= wrap_add(window_ptr, 32'd1);
        else             chars      <= chars + CNT_W'(1);
      end
    end
  end

  lz77_window_ram #(
    .DEPTH  (WINDOW_SIZE),
    .ADDR_W (PTR_W)
  ) u_window (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (src_ptr),
    .rdata (ram_rdata)
  );

  assign stream.inReady  = in_ready;
  assign stream.outValid = out_valid;
  assign stream.outData  = out_data;
  assign bytesWritten    = bytes_written;
  assign busy            = state inside {FLAG, LITERAL, MATCH_HDR, COPY};
  assign done            = (state == DONE);
  assign error           = (state == ERROR);

endmodule

// File: tb/tb_lz77_decompressor.sv
// Scoreboard bench for lz77_decompressor: a byte-history model predicts the
// output stream, and a monitor compares every accepted byte.
module tb_lz77_decompressor;
  import lz77_pkg::*;

  localparam int W = LZ77_WINDOW_SIZE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [31:0] bytes_written;

  lz77_decompressor_if bus ();

  lz77_decompressor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .bytesWritten (bytes_written),
    .stream       (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sb_q[$];
  logic [7:0] history[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: a byte transfers on the next rising edge when valid and ready
  // are both seen high at the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.outValid && bus.outReady) begin
      if (sb_q.size() == 0) check("out_unexpected", 32'(bus.outData), 32'h100);
      else                  check("out_byte", 32'(bus.outData), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_byte(input logic [7:0] b);
    history.push_back(b);
    sb_q.push_back(b);
  endtask

  task automatic model_match(input int off, input int len);
    int chars, base;
    chars = (history.size() < W) ? history.size() : W;
    if (len < LZ77_MIN_MATCH || off >= chars) return;
    base = history.size() - chars + off;
    for (int i = 0; i < len; i++) expect_byte(history[base + i]);
  endtask

  task automatic send_bit(input logic b, input logic last);
    int budget;
    bus.inBit     = b;
    bus.lastToken = last;
    bus.inValid   = 1'b1;
    budget = 200;
    do begin
      @(negedge clk);
      budget--;
    end while (!bus.inReady && budget > 0);
    if (!bus.inReady) check("bit_accept_timeout", 32'(bus.inReady), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_field(input logic [31:0] value, input int nbits, input logic last);
    for (int i = nbits - 1; i >= 0; i--) send_bit(value[i], last);
  endtask

  task automatic send_literal(input logic [7:0] b, input logic last);
    expect_byte(b);
    send_bit(1'b1, last);
    send_field(32'(b), 8, last);
    bus.inValid = 1'b0;
  endtask

  task automatic send_match(input int off, input int len, input logic last);
    model_match(off, len);
    send_bit(1'b0, last);
    send_field(32'(off), LZ77_OFFSET_BITS, last);
    send_field(32'(len), LZ77_LENGTH_BITS, last);
    bus.inValid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.inValid   = 1'b0;
    bus.inBit     = 1'b0;
    bus.lastToken = 1'b0;
    bus.outReady  = 1'b1;
    sb_q.delete();
    history.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_done"},      32'(done),         32'd0);
    check({tag, "_error"},     32'(error),        32'd0);
    check({tag, "_out_valid"}, 32'(bus.outValid), 32'd0);
    check({tag, "_out_data"},  32'(bus.outData),  32'd0);
    check({tag, "_in_ready"},  32'(bus.inReady),  32'd0);
    check({tag, "_bytes"},     bytes_written,     32'd0);
  endtask

  task automatic start_stream(input string tag);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int budget;
    budget = 500;
    while (!(done || error) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_finished"}, 32'(done || error), 32'd1);
    check({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input int exp_bytes);
    check({tag, "_done"},     32'(done),        32'(exp_done));
    check({tag, "_error"},    32'(error),       32'(!exp_done));
    check({tag, "_busy"},     32'(busy),        32'd0);
    check({tag, "_in_ready"}, 32'(bus.inReady), 32'd0);
    check({tag, "_bytes"},    bytes_written,    32'(exp_bytes));
  endtask

  initial begin
    apply_reset();
    check_reset("rst");

    // Two literals, the second marked last.
    start_stream("lit");
    send_literal(8'h41, 1'b0);
    send_literal(8'h42, 1'b1);
    wait_end("lit");
    check_end("lit", 1'b1, 2);

    // "ABC" then a self-overlapping match from the oldest byte.
    apply_reset();
    start_stream("abc");
    send_literal(8'h41, 1'b0);
    send_literal(8'h42, 1'b0);
    send_literal(8'h43, 1'b0);
    send_match(0, 6, 1'b1);
    wait_end("abc");
    check_end("abc", 1'b1, 9);

    // Offset beyond the two stored bytes must trap in ERROR.
    apply_reset();
    start_stream("bad");
    send_literal(8'h78, 1'b0);
    send_literal(8'h79, 1'b0);
    send_match(5, 3, 1'b0);
    wait_end("bad");
    check_end("bad", 1'b0, 2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("bad_start_ignored_error", 32'(error), 32'd1);
    check("bad_start_ignored_busy",  32'(busy),  32'd0);

    // Length-8 copy with the downstream stalled for 10 cycles mid-copy.
    apply_reset();
    start_stream("stall");
    for (int i = 0; i < 5; i++) send_literal(8'(8'h10 + i), 1'b0);
    send_match(1, 8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(bus.inReady),  32'd0);
      check("stall_out_valid", 32'(bus.outValid), 32'd1);
      check("stall_out_data",  32'(bus.outData),  32'(sb_q[0]));
    end
    @(posedge clk);
    #1;
    bus.outReady = 1'b1;
    wait_end("stall");
    check_end("stall", 1'b1, 13);

    // 1100 literals wrap the window; offset 0 then names input byte 77.
    apply_reset();
    start_stream("wrap");
    for (int i = 0; i < 1100; i++) send_literal(8'(i * 37 + 11), 1'b0);
    send_match(0, 4, 1'b1);
    wait_end("wrap");
    check_end("wrap", 1'b1, 1104);

    // Reset during the 10th bit of a match token, then a fresh stream.
    apply_reset();
    start_stream("midrst");
    send_literal(8'h70, 1'b0);
    send_literal(8'h71, 1'b0);
    send_literal(8'h72, 1'b0);
    send_bit(1'b0, 1'b1);
    send_field(32'd0, 8, 1'b1);
    bus.inBit   = 1'b1;
    bus.inValid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    bus.inValid = 1'b0;
    sb_q.delete();
    history.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_stream("fresh");
    send_literal(8'h78, 1'b0);
    send_literal(8'h79, 1'b0);
    send_literal(8'h7a, 1'b0);
    send_match(0, 3, 1'b1);
    wait_end("fresh");
    check_end("fresh", 1'b1, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lz77_decompressor.md
LZ77_DECOMPRESSOR -- requirements
Module: lz77_decompressor

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 1023: history window depth in bytes.
REQ-002 SHALL have parameter OFFSET_BITS, default 12: width of the match-token offset field.
REQ-003 SHALL have parameter LENGTH_BITS, default 6: width of the match-token length field.
REQ-004 SHALL have parameter MIN_MATCH, default 3: smallest legal match length.
REQ-005 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1: pulse in IDLE that begins a stream.
REQ-008 SHALL have port busy  output  1: high from the start acceptance until DONE or ERROR.
REQ-009 SHALL have port done  output  1: sticky high in DONE.
REQ-010 SHALL have port error  output  1: sticky high in ERROR.
REQ-011 SHALL have port inBit  input  1: serial token bit, MSB first.
REQ-012 SHALL have port inValid  input  1 and port inReady  output  1: bit handshake, a transfer occurs when both are high.
REQ-013 SHALL have port lastToken  input  1: sampled with the first (flag) bit of the final token.
REQ-014 SHALL have port outData  output  8: decoded byte.
REQ-015 SHALL have port outValid  output  1 and port outReady  input  1: byte handshake.
REQ-016 SHALL have port bytesWritten  output  32: count of bytes accepted downstream.

Function
REQ-017 SHALL decode the following token format, where bit 0 is the flag: flag 1 is followed by an 8-bit literal (9 bits total); flag 0 is followed by offset[OFFSET_BITS-1:0] and then length[LENGTH_BITS-1:0] (19 bits total).
REQ-018 SHALL implement the states IDLE, FLAG, LITERAL, MATCH_HDR, COPY, DONE and ERROR.
REQ-019 SHALL transition IDLE->FLAG on start, with busy rising on the next edge.
REQ-020 SHALL, in FLAG, branch on the accepted bit to LITERAL (1) or MATCH_HDR (0), and latch lastToken.
REQ-021 SHALL hold inReady=1 only in FLAG, LITERAL and MATCH_HDR while outValid=0; it SHALL be 0 in every other state.
REQ-022 SHALL, in LITERAL, shift in 8 bits; on the 8th bit it SHALL load outData, assert outValid, and append the byte to the window in the same cycle.
REQ-023 SHALL, in MATCH_HDR, shift in 18 bits, then go to ERROR if length<MIN_MATCH or offset>=charsInWindow; otherwise it SHALL go to COPY.
REQ-024 SHALL, on entering COPY, latch srcPtr=(windowPtr+offset) mod WINDOW_SIZE, where windowPtr points to the oldest stored byte.
REQ-025 SHALL, in COPY, issue one registered window read per byte (1-cycle read latency), emit the byte on outData, append it to the window, and increment srcPtr mod WINDOW_SIZE.
REQ-026 SHALL read each source byte before any write to the same address; when the window is full, the append overwrites windowPtr and windowPtr advances, which never overtakes srcPtr.
REQ-027 SHALL sustain 1 byte per cycle in COPY while outReady=1, and SHALL stall without losing or duplicating bytes while outReady=0.
REQ-028 SHALL hold outData and outValid stable until outReady, and SHALL increment bytesWritten on each outValid&&outReady.
REQ-029 SHALL, when a token completes (last byte accepted downstream), go to DONE if the latched lastToken=1; otherwise it SHALL go to FLAG.
REQ-030 SHALL increment charsInWindow saturating at WINDOW_SIZE; once saturated, appends SHALL advance windowPtr instead.
REQ-031 SHALL ignore inValid outside the bit-accepting states.
REQ-032 SHALL ignore start outside IDLE.
REQ-033 SHALL keep DONE and ERROR terminal until reset, with busy=0 in both.

Reset
REQ-034 SHALL, on rst_n low, asynchronously force state=IDLE, busy=0, done=0, error=0, outValid=0, outData=0, inReady=0, bytesWritten=0, charsInWindow=0, windowPtr=0, and clear the shift counters.
REQ-035 SHALL abandon any in-flight token when reset occurs mid-stream; window RAM contents are not cleared and are don't-care.

Structure
REQ-036 SHALL take the token field widths, MIN_MATCH, WINDOW_SIZE and the state encoding from a shared package lz77_pkg, which is also used by the compressor.
REQ-037 SHALL place the window in a sub-module lz77_window_ram: 1 write port, 1 registered read port, block-RAM style.

Verification
REQ-038 SHALL verify that bits 1,0x41 then 1,0x42 with lastToken on the second -> outData 0x41, 0x42; done=1; bytesWritten=2.
REQ-039 SHALL verify that literals "ABC" followed by a match token offset=0 len=6 (last) -> output ABCABCABC; bytesWritten=9.
REQ-040 SHALL verify that a match token offset=5 len=3 with charsInWindow=2 -> error=1, no output bytes, busy=0.
REQ-041 SHALL verify that holding outReady=0 for 10 cycles during a len=8 copy -> the same byte sequence is produced with no loss or duplication, and inReady=0 throughout.
REQ-042 SHALL verify that 1100 literals followed by a match offset=0 len=4 -> output equals input bytes 77..80 (window wrap, oldest at index 77).
REQ-043 SHALL verify that asserting rst_n low during the 10th bit of a match token -> all outputs return to reset values, and a new start decodes a fresh stream correctly.
